// File: rtl/shift_right_iterative.sv
// rtl/shift_right_iterative.sv - one-bit-per-clock right shifter (SRL/SRA), rotate under SHIFT_RIGHT_ROTATE_EN
module shift_right_iterative #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] shamt,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_n;
    logic [N-1:0]  work, work_n, out_n, shifted;
    logic [SW-1:0] cnt, cnt_n;
    logic          fill;

`ifdef SHIFT_RIGHT_ROTATE_EN
    logic [1:0] mode_r, mode_n;
    wire  [1:0] mode_in = mode;

    // Rotate overrides the arithmetic/logical choice entirely.
    assign fill = mode_r[1] ? work[0] : (mode_r[0] & work[N-1]);
`else
    logic       mode_r, mode_n;
    wire        mode_in = mode[0];
    logic       unused_mode;

    assign unused_mode = mode[1];
    assign fill        = mode_r & work[N-1];
`endif

    assign shifted = {fill, work[N-1:1]};

    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = cnt;
        mode_n  = mode_r;
        out_n   = out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    work_n = in_data;
                    cnt_n  = shamt;
                    mode_n = mode_in;
                    if (shamt == '0) begin
                        state_n = DONE;
                        out_n   = in_data;
                    end else begin
                        state_n = SHIFT;
                    end
                end else if (state == DONE) begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                work_n = shifted;
                cnt_n  = cnt - {{(SW-1){1'b0}}, 1'b1};
                if (cnt == {{(SW-1){1'b0}}, 1'b1}) begin
                    state_n = DONE;
                    out_n   = shifted;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            mode_r <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            work   <= work_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            out    <= out_n;
            busy   <= (state_n == SHIFT);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_shift_right_iterative.sv
// tb/tb_shift_right_iterative.sv - scoreboard bench for shift_right_iterative
module tb_shift_right_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  shamt = '0;
    logic [1:0]  mode = '0;
    logic        busy, done;
    logic [31:0] out;

    shift_right_iterative #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .shamt(shamt), .mode(mode), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        logic [31:0] r;
`ifdef SHIFT_RIGHT_ROTATE_EN
        if (m[1]) begin
            r = (d >> s) | (d << (6'd32 - {1'b0, s}));
            if (s == 0) r = d;
            return r;
        end
`endif
        if (m[0]) r = $signed(d) >>> s;
        else      r = d >> s;
        return r;
    endfunction

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out, e.res);
                    chk("latency", cyc, e.cyc);
                end
                last_out = out;
            end else if (busy) begin
                chk("out_stable", out, last_out);
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        exp_t e;
        e.res = model(d, s, m);
        e.cyc = cyc + s + 1;
        sb.push_back(e);
        start = 1'b1; in_data = d; shamt = s; mode = m;
        @(posedge clk); #1;
        start = 1'b0; in_data = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done) return;
            @(posedge clk); #1;
        end
        chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        step(2);
        chk("rst_out", out, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step(1);

        issue(32'hF000_0000, 5'd4, 2'b00);
        chk("srl_busy_c1", {31'd0, busy}, 32'd1);
        wait_done();
        chk("srl4", out, 32'h0F00_0000);
        step(1);

        issue(32'h8000_0000, 5'd31, 2'b01);
        wait_done();
        chk("sra31", out, 32'hFFFF_FFFF);
        step(1);
        issue(32'h8000_0000, 5'd31, 2'b00);
        wait_done();
        chk("srl31", out, 32'h0000_0001);
        step(1);

        issue(32'h1234_5678, 5'd0, 2'b00);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_out", out, 32'h1234_5678);
        step(1);

        issue(32'h0040_0010, 5'd2, 2'b00);
        wait_done();
        chk("word_idx", out, 32'h0010_0004);
        step(1);

        // Restart attempt in cycle 2 of a running shift must be ignored.
        issue(32'hF000_0000, 5'd4, 2'b00);
        start = 1'b1; in_data = 32'h0000_FFFF; shamt = 5'd1; mode = 2'b01;
        step(1);
        start = 1'b0;
        wait_done();
        chk("ignore_restart", out, 32'h0F00_0000);

        // Start held during DONE: no bubble between results.
        issue(32'hAAAA_5555, 5'd3, 2'b01);
        wait_done();
        issue(32'h7FFF_0000, 5'd0, 2'b00);
        issue(32'h8765_4321, 5'd1, 2'b01);
        wait_done();
        step(1);

        // Reset in cycle 3 of a 10-step shift discards the operation.
        issue(32'hFFFF_0000, 5'd10, 2'b01);
        step(1);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        chk("midrst_out", out, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        last_out = '0;
        step(15);

        issue(32'h0000_0100, 5'd8, 2'b00);
        wait_done();
        chk("post_rst", out, 32'h0000_0001);
        step(1);

        issue(32'h0000_0001, 5'd1, 2'b10);
        wait_done();
`ifdef SHIFT_RIGHT_ROTATE_EN
        chk("rotate", out, 32'h8000_0000);
`else
        chk("rotate_off", out, 32'h0000_0000);
`endif
        issue(32'h8000_0000, 5'd4, 2'b11);
        wait_done();
        step(1);

        for (int i = 0; i < 24; i++) begin
            issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
            wait_done();
            if ($urandom_range(0, 1) == 1) step(1);
        end

        step(5);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
